// File: rtl/special_pc_pkg.sv
// Shared types and default sizes for the special PC learning table.
package special_pc_pkg;

  localparam int unsigned DefAddressBits = 20;
  localparam int unsigned DefDataWidth   = 32;
  localparam int unsigned DefNumEntries  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StSearch,
    StResp
  } spc_state_e;

  // One table entry at the default storage width.
  typedef struct packed {
    logic                    valid;
    logic [DefDataWidth-1:0] tag;
    logic [DefDataWidth-1:0] target;
  } spc_entry_t;

endpackage

// File: rtl/special_pc_unit_if.sv
// Request/response bundle between the fetch PC path (master) and special_pc_unit (slave).
interface special_pc_unit_if #(
  parameter int unsigned ADDRESS_BITS = special_pc_pkg::DefAddressBits
);
  logic                    en;
  logic [ADDRESS_BITS-1:0] curr_pc;
  logic                    done;
  logic                    valid;
  logic [ADDRESS_BITS-1:0] out_pc;

  modport master (
    output en,
    output curr_pc,
    input  done,
    input  valid,
    input  out_pc
  );

  modport slave (
    input  en,
    input  curr_pc,
    output done,
    output valid,
    output out_pc
  );
endinterface

// File: rtl/spc_table.sv
// Entry storage for special_pc_unit: one write port, one indexed target read and a
// per-entry match vector against the search key.
module spc_table
  import special_pc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DefDataWidth,
  parameter int unsigned NUM_ENTRIES = DefNumEntries,
  localparam int unsigned IdxW       = $clog2(NUM_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [IdxW-1:0]        wr_idx,
  input  logic [DATA_WIDTH-1:0]  wr_tag,
  input  logic [DATA_WIDTH-1:0]  wr_target,
  input  logic [DATA_WIDTH-1:0]  key,
  output logic [NUM_ENTRIES-1:0] match_vec,
  input  logic [IdxW-1:0]        rd_idx,
  output logic [DATA_WIDTH-1:0]  rd_target
);

  logic [NUM_ENTRIES-1:0] valid_q;
  logic [DATA_WIDTH-1:0]  tag_q    [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]  target_q [NUM_ENTRIES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else if (we) begin
      valid_q[wr_idx]  <= 1'b1;
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

  always_comb begin
    match_vec = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      match_vec[i] = valid_q[i] && (tag_q[i] == key);
    end
  end

  assign rd_target = target_q[rd_idx];

endmodule

// File: rtl/special_pc_unit.sv
// special_pc_unit: remembers the PC that followed a triggering PC and replays it on a hit.
// Define SPECIAL_PC_PARALLEL_LOOKUP_EN to compare every entry in the first search cycle.
module special_pc_unit
  import special_pc_pkg::*;
#(
  parameter int unsigned ADDRESS_BITS = DefAddressBits,
  parameter int unsigned DATA_WIDTH   = DefDataWidth,
  parameter int unsigned NUM_ENTRIES  = DefNumEntries
) (
  input logic              clk,
  input logic              rst,
  special_pc_unit_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NUM_ENTRIES);

  spc_state_e              state_q;
  logic                    en_q;
  logic                    arm_q;
  logic [ADDRESS_BITS-1:0] key_pc_q;
  logic [ADDRESS_BITS-1:0] succ_pc_q;
  logic [ADDRESS_BITS-1:0] out_pc_q;
  logic [IdxW-1:0]         idx_q;
  logic [IdxW-1:0]         rr_q;
  logic                    done_q;
  logic                    valid_q;

  logic                    trigger;
  logic                    hit;
  logic                    last;
  logic                    tbl_we;
  logic [ADDRESS_BITS-1:0] succ_now;
  logic [DATA_WIDTH-1:0]   key_word;
  logic [DATA_WIDTH-1:0]   succ_word;
  logic [NUM_ENTRIES-1:0]  match_vec;
  logic [IdxW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0]   rd_target;

  // arm_q blocks a request when en is already high as reset releases; en must be seen low first.
  assign trigger   = bus.en & ~en_q & arm_q & (state_q == StIdle);
  // The successor is curr_pc on the first search edge, so a decision on that edge uses it live.
  assign succ_now  = (idx_q == '0) ? bus.curr_pc : succ_pc_q;
  assign key_word  = DATA_WIDTH'(key_pc_q);
  assign succ_word = DATA_WIDTH'(succ_now);

`ifdef SPECIAL_PC_PARALLEL_LOOKUP_EN
  always_comb begin
    rd_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (match_vec[i]) rd_idx = IdxW'(i);
    end
  end
  assign hit  = |match_vec;
  assign last = 1'b1;
`else
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_ENTRIES - 1);
  assign rd_idx = idx_q;
  assign hit    = match_vec[idx_q];
  assign last   = (idx_q == LastIdx);
`endif

  assign tbl_we = (state_q == StSearch) & ~hit & last;

  spc_table #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_table (
    .clk      (clk),
    .rst      (rst),
    .we       (tbl_we),
    .wr_idx   (rr_q),
    .wr_tag   (key_word),
    .wr_target(succ_word),
    .key      (key_word),
    .match_vec(match_vec),
    .rd_idx   (rd_idx),
    .rd_target(rd_target)
  );

  if (DATA_WIDTH > ADDRESS_BITS) begin : g_unused_hi
    logic unused_target_hi;
    assign unused_target_hi = ^rd_target[DATA_WIDTH-1:ADDRESS_BITS];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      en_q      <= 1'b0;
      arm_q     <= 1'b0;
      key_pc_q  <= '0;
      succ_pc_q <= '0;
      out_pc_q  <= '0;
      idx_q     <= '0;
      rr_q      <= '0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      en_q <= bus.en;
      if (!bus.en) arm_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          done_q  <= 1'b0;
          valid_q <= 1'b0;
          if (trigger) begin
            state_q  <= StSearch;
            key_pc_q <= bus.curr_pc;
            idx_q    <= '0;
          end
        end
        StSearch: begin
          if (idx_q == '0) succ_pc_q <= bus.curr_pc;
          if (hit) begin
            out_pc_q <= rd_target[ADDRESS_BITS-1:0];
            valid_q  <= 1'b1;
            done_q   <= 1'b1;
            state_q  <= StResp;
          end else if (last) begin
            out_pc_q <= succ_now;
            valid_q  <= 1'b0;
            done_q   <= 1'b1;
            rr_q     <= rr_q + 1'b1;
            state_q  <= StResp;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StResp: begin
          done_q  <= 1'b0;
          valid_q <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.done   = done_q;
  assign bus.valid  = valid_q;
  assign bus.out_pc = out_pc_q;

endmodule

// File: tb/tb_special_pc_unit.sv
// Bench for special_pc_unit: a table/queue model predicts every done/valid/out_pc cycle.
module tb_special_pc_unit;
  import special_pc_pkg::*;

  localparam int unsigned AB = 20;
  localparam int unsigned N  = 8;
`ifdef SPECIAL_PC_PARALLEL_LOOKUP_EN
  localparam int MissLat = 1;
`else
  localparam int MissLat = 8;
`endif

  typedef struct {
    int          cyc;
    logic        v;
    logic [19:0] out;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  special_pc_unit_if #(.ADDRESS_BITS(AB)) bus ();

  special_pc_unit #(
    .ADDRESS_BITS(AB),
    .DATA_WIDTH  (32),
    .NUM_ENTRIES (N)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  spc_entry_t  model [N];
  int          rr;
  exp_t        exp_q [$];
  logic [19:0] out_model = '0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          last_t = 0;
  int          last_done_cyc = 0;
  logic        last_done_valid = 1'b0;
  logic        ed, ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  // Compare process: every cycle, outputs must equal the model's prediction.
  always @(negedge clk) begin
    ed = 1'b0;
    ev = 1'b0;
    if (!rst) begin
      out_model = '0;
      exp_q.delete();
    end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      ed        = 1'b1;
      ev        = exp_q[0].v;
      out_model = exp_q[0].out;
      void'(exp_q.pop_front());
    end
    check("done", 32'(bus.done), 32'(ed));
    check("valid", 32'(bus.valid), 32'(ev));
    check("out_pc", 32'(bus.out_pc), 32'(out_model));
    if (bus.done) begin
      last_done_cyc   = cyc;
      last_done_valid = bus.valid;
    end
  end

  task automatic mdl_reset();
    for (int i = 0; i < N; i++) model[i] = '0;
    rr = 0;
  endtask

  // One request: en follows pat (bit k = level before edge T+k), curr_pc steps by 4.
  task automatic req(input logic [19:0] pc, input logic [7:0] pat);
    int          lat;
    int          hit_i;
    int          t;
    logic        v;
    logic [19:0] o;
    @(posedge clk);
    #2;
    t     = cyc + 1;
    hit_i = -1;
    for (int i = 0; i < N; i++) begin
      if (model[i].valid && model[i].tag == 32'(pc)) hit_i = i;
    end
    if (hit_i >= 0) begin
      lat = hit_i + 1;
      v   = 1'b1;
      o   = model[hit_i].target[19:0];
    end else begin
      lat       = N;
      v         = 1'b0;
      o         = pc + 20'd4;
      model[rr] = '{valid: 1'b1, tag: 32'(pc), target: 32'(o)};
      rr        = (rr + 1) % N;
    end
`ifdef SPECIAL_PC_PARALLEL_LOOKUP_EN
    lat = 1;
`endif
    exp_q.push_back('{cyc: t + lat, v: v, out: o});
    for (int k = 0; k < lat + 4; k++) begin
      bus.en      = (k < 8) ? pat[k] : 1'b0;
      bus.curr_pc = pc + 20'(4 * k);
      @(posedge clk);
      #2;
    end
    bus.en = 1'b0;
    last_t = t;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    mdl_reset();
    // Reset with en high: nothing may start after release until en toggles.
    bus.en      = 1'b1;
    bus.curr_pc = 20'h00040;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    check("rst_out_pc", 32'(bus.out_pc), 32'h0);
    check("rst_valid", 32'(bus.valid), 32'h0);
    bus.en = 1'b0;

    // Empty table: miss learns the successor.
    req(20'hB0013, 8'b1);
    check("miss_lat", 32'(last_done_cyc - last_t), 32'(MissLat));
    check("miss_out", 32'(bus.out_pc), 32'h000B0017);
    check("miss_valid", 32'(last_done_valid), 32'h0);

    // Same PC hits entry 0.
    req(20'hB0013, 8'b1);
    check("hit0_lat", 32'(last_done_cyc - last_t), 32'h1);
    check("hit0_out", 32'(bus.out_pc), 32'h000B0017);
    check("hit0_valid", 32'(last_done_valid), 32'h1);

    // en held two cycles, then a second rising edge during search.
    req(20'h12340, 8'b11);
    req(20'h00100, 8'b101);
    req(20'h12340, 8'b1);
    check("hit1_out", 32'(bus.out_pc), 32'h00012344);

    // Clean reset, then nine distinct misses wrap rr over entry 0.
    #1 rst = 1'b0;
    mdl_reset();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    for (int k = 0; k < 9; k++) req(20'h10000 + 20'(k * 256), 8'b1);
    req(20'h10000, 8'b1);
    check("wrap_lat", 32'(last_done_cyc - last_t), 32'(MissLat));
    check("wrap_valid", 32'(last_done_valid), 32'h0);
    req(20'h10200, 8'b1);
    check("hit2_out", 32'(bus.out_pc), 32'h00010204);
    check("hit2_valid", 32'(last_done_valid), 32'h1);

    // Reset in the middle of a search aborts it and empties the table.
    @(posedge clk);
    #2;
    bus.en      = 1'b1;
    bus.curr_pc = 20'h10300;
    repeat (3) begin
      @(posedge clk);
      #2;
      bus.curr_pc = bus.curr_pc + 20'd4;
    end
    #1 rst = 1'b0;
    mdl_reset();
    bus.en = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("abort_done", 32'(bus.done), 32'h0);
    check("abort_out_pc", 32'(bus.out_pc), 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    req(20'h10200, 8'b1);
    check("post_abort_lat", 32'(last_done_cyc - last_t), 32'(MissLat));
    check("post_abort_valid", 32'(last_done_valid), 32'h0);

    repeat (3) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/special_pc_unit.md
# special_pc_unit

Small learning table that remembers, for a triggering program counter, the PC that followed it. When triggered by a rising edge on `en`, the unit captures `curr_pc` and searches its entry table. On a hit it returns the remembered successor as `out_pc` with `valid`. On a miss it learns the successor (the `curr_pc` seen one cycle after capture), writes it in, and returns it without `valid`. It sits beside the fetch PC path as a side unit; it never stalls the pipeline, and `done` marks completion of each request.

## Interface
- `ADDRESS_BITS`, 20, width of every PC value.
- `DATA_WIDTH`, 32, width of a table storage word; must be ≥ `ADDRESS_BITS`; PC values are zero-extended into it.
- `NUM_ENTRIES`, 8, table depth; power of two, ≥ 2.
- `clk`  in  1  single clock, all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `en`  in  1  trigger; a request starts on its rising edge only.
- `curr_pc`  in  `ADDRESS_BITS`  current fetch PC, sampled every cycle.
- `done`  out  1  one-cycle completion pulse.
- `valid`  out  1  high with `done` only on a table hit.
- `out_pc`  out  `ADDRESS_BITS`  result PC; registered, holds its value until the next `done`.

## Operation
- Edge detect: `en_q` registers `en`. A trigger is `en & ~en_q` while in IDLE. A trigger in any other state is dropped; `en_q` still updates.
- State machine:
  - IDLE.
  - SEARCH: captures `key_pc` ← `curr_pc` on the trigger edge, and `succ_pc` ← `curr_pc` on the first SEARCH edge.
  - RESP: transitions back to IDLE.
- SEARCH compares `key_pc` against entry `idx` = 0..`NUM_ENTRIES`-1, one entry per cycle. Only entries with their valid bit set can match.
- Hit at `idx` = i:
  - `out_pc` ← target[i]; `valid` ← 1; go to RESP.
  - The entry is not modified.
- Miss after the last index:
  - Write {valid=1, tag=`key_pc`, target=`succ_pc`} at the round-robin pointer `rr`.
  - `rr` ← `rr`+1, wrapping to 0 after `NUM_ENTRIES`-1.
  - `out_pc` ← `succ_pc`; `valid` ← 0; go to RESP.
- The table holds at most one valid entry per tag. A missed tag is never already present, so no duplicates arise.
- RESP lasts one cycle: `done`=1 (and `valid` as set), then both return to 0 and the state returns to IDLE.
- No PC arithmetic is performed. All compares are full `ADDRESS_BITS` equality.

## Timing
- Reset values:
  - Outputs: `done`=0, `valid`=0, `out_pc`=0.
  - State: IDLE, `en_q`=0, `rr`=0, all entry valid bits 0.
- Reset mid-request aborts the request. No write or `done` occurs for it.
- Trigger sampled at edge T:
  - Hit at index i is decided at edge T+1+i.
  - A miss is decided at edge T+`NUM_ENTRIES` (the table write happens on that same edge).
- `done`/`valid` are high for exactly the one cycle following the decision edge. The earliest next trigger is sampled at the edge that ends the RESP cycle.
- `en` held high for several cycles produces exactly one request. Re-triggering requires `en` to be low for at least one sampled edge.

## Configuration
- `SPECIAL_PC_PARALLEL_LOOKUP_EN`:
  - Defined: all entries are compared in the first SEARCH cycle. Both hit and miss are decided at edge T+1.
  - Undefined: sequential search as specified above.
- Functional results (entry contents, `out_pc`, `valid`) are identical in both modes; only latency differs.

## Structure
- Package `special_pc_pkg` holds:
  - the state enum (IDLE, SEARCH, RESP);
  - the entry struct {valid, tag, target};
  - the default parameter constants.
- Sub-module `spc_table`: entry storage with one write port, an indexed read, and the parallel match vector used under the macro. The FSM, edge detection and output registers stay in the top module.

## Test plan
- Reset with `rst`=0, `en`=1 -> `done`=0, `valid`=0, `out_pc`=0; no request after release until `en` goes low then high.
- Empty table, trigger at `curr_pc`=0xB0013 with `curr_pc`+4 each cycle -> miss: `done` pulses once 8 cycles after the trigger edge, `valid`=0, `out_pc`=0xB0017.
- Trigger again with `curr_pc`=0xB0013 -> hit at index 0: `done` and `valid` high for one cycle at T+1 (plus one), `out_pc`=0xB0017.
- `en` held high for 2 cycles -> exactly one `done`. A second rising edge during SEARCH -> ignored.
- Nine distinct-PC misses -> the ninth overwrites entry 0 (`rr` wraps); re-triggering the first PC then misses.
- `rst` asserted during SEARCH -> no `done`; all outputs 0; table empty afterward.
